// File: rtl/mod_addsub_ctrl.sv
// Modular add/subtract sequencer driving one shared multi-precision adder.
// Computes (a + b) mod M or (a - b) mod M with one or two adder passes.
module mod_addsub_ctrl #(
    parameter int WIDTH = 1027
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             adder_start,
    output logic             adder_subtract,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    input  logic [WIDTH:0]   adder_result,
    input  logic             adder_done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P1_GO   = 3'd1,
        P1_WAIT = 3'd2,
        P2_GO   = 3'd3,
        P2_WAIT = 3'd4,
        FIN     = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] r1_q, r1_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             adder_start_q, adder_start_d;
    logic             adder_sub_q, adder_sub_d;
    logic [WIDTH-1:0] adder_a_q, adder_a_d;
    logic [WIDTH-1:0] adder_b_q, adder_b_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= IDLE;
            sub_q         <= 1'b0;
            m_q           <= '0;
            r1_q          <= '0;
            result_q      <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            adder_start_q <= 1'b0;
            adder_sub_q   <= 1'b0;
            adder_a_q     <= '0;
            adder_b_q     <= '0;
        end else begin
            state_q       <= state_d;
            sub_q         <= sub_d;
            m_q           <= m_d;
            r1_q          <= r1_d;
            result_q      <= result_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            adder_start_q <= adder_start_d;
            adder_sub_q   <= adder_sub_d;
            adder_a_q     <= adder_a_d;
            adder_b_q     <= adder_b_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sub_d         = sub_q;
        m_d           = m_q;
        r1_d          = r1_q;
        result_d      = result_q;
        done_d        = 1'b0;
        busy_d        = busy_q;
        adder_start_d = 1'b0;
        adder_sub_d   = adder_sub_q;
        adder_a_d     = adder_a_q;
        adder_b_d     = adder_b_q;

        case (state_q)
            IDLE: begin
                // Operands go straight to the adder ports; only mode and M are kept.
                if (start) begin
                    sub_d         = subtract;
                    m_d           = in_m;
                    adder_a_d     = in_a;
                    adder_b_d     = in_b;
                    adder_sub_d   = subtract;
                    adder_start_d = 1'b1;
                    busy_d        = 1'b1;
                    state_d       = P1_GO;
                end
            end
            P1_GO: begin
                state_d = P1_WAIT;
            end
            P1_WAIT: begin
                if (adder_done) begin
                    r1_d = adder_result[WIDTH-1:0];
                    if (sub_q && !adder_result[WIDTH]) begin
                        result_d = adder_result[WIDTH-1:0];
                        done_d   = 1'b1;
                        state_d  = FIN;
                    end else begin
                        state_d = P2_GO;
                    end
                end
            end
            P2_GO: begin
                // Correction pass: add does r1-M, sub does r1+M.
                adder_start_d = 1'b1;
                adder_a_d     = r1_q;
                adder_b_d     = m_q;
                adder_sub_d   = !sub_q;
                state_d       = P2_WAIT;
            end
            P2_WAIT: begin
                // A done seen alongside our own start pulse is stale (adder latency >= 1).
                if (adder_done && !adder_start_q) begin
                    if (!sub_q && adder_result[WIDTH])
                        result_d = r1_q;
                    else
                        result_d = adder_result[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = FIN;
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result         = result_q;
    assign done           = done_q;
    assign busy           = busy_q;
    assign adder_start    = adder_start_q;
    assign adder_subtract = adder_sub_q;
    assign adder_a        = adder_a_q;
    assign adder_b        = adder_b_q;

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Randomized self-checking bench for mod_addsub_ctrl with a behavioural
// multi-precision adder of configurable latency.
module tb_mod_addsub_ctrl;
    localparam int W = 1027;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic         subtract = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0, in_m = '0;
    logic [W-1:0] result;
    logic         done, busy, adder_start, adder_subtract;
    logic [W-1:0] adder_a, adder_b;
    logic [W:0]   adder_result;
    logic         adder_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat_cfg = 1;
    int stale_cfg = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mod_addsub_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
        .in_a(in_a), .in_b(in_b), .in_m(in_m),
        .result(result), .done(done), .busy(busy),
        .adder_start(adder_start), .adder_subtract(adder_subtract),
        .adder_a(adder_a), .adder_b(adder_b),
        .adder_result(adder_result), .adder_done(adder_done)
    );

    // Adder model: done is high exactly lat_cfg cycles after the start cycle,
    // optionally held stale_cfg extra cycles.
    initial begin
        int cnt;
        int hold;
        logic [W:0] pend;
        cnt = 0; hold = 0; pend = '0;
        adder_done = 1'b0;
        adder_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!resetn) begin
                cnt = 0; hold = 0; adder_done = 1'b0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        adder_done = 1'b1;
                        adder_result = pend;
                        hold = stale_cfg;
                    end
                end else if (adder_done) begin
                    if (hold > 0) hold--;
                    else adder_done = 1'b0;
                end
                if (adder_start) begin
                    if (adder_subtract) pend = {1'b0, adder_a} - {1'b0, adder_b};
                    else                pend = {1'b0, adder_a} + {1'b0, adder_b};
                    cnt = lat_cfg;
                end
            end
        end
    end

    function automatic logic [W-1:0] rnd_bits(input int nb);
        logic [W-1:0] v;
        logic [W-1:0] mask;
        v = '0;
        for (int i = 0; i < W; i += 32) v = (v << 32) | {{(W-32){1'b0}}, 32'($urandom)};
        mask = (W'(1) << nb) - W'(1);
        return v & mask;
    endfunction

    function automatic logic [W-1:0] ref_mod(input logic s, input logic [W-1:0] a, b, m);
        logic [W:0] t;
        if (!s) begin
            t = {1'b0, a} + {1'b0, b};
            if (t >= {1'b0, m}) t = t - {1'b0, m};
        end else if (a >= b) begin
            t = {1'b0, a} - {1'b0, b};
        end else begin
            t = {1'b0, a} + {1'b0, m} - {1'b0, b};
        end
        return t[W-1:0];
    endfunction

    task automatic run_op(input logic s, input logic [W-1:0] a, b, m, input int la,
                          input int stale, input bit extra_start, input string name);
        logic [W-1:0] exp_r, got_r;
        int passes, exp_cyc, t0, n_starts, k, dcyc;
        bit got, busy_ok, first_ok;
        exp_r  = ref_mod(s, a, b, m);
        passes = (!s || a < b) ? 2 : 1;
        lat_cfg = la;
        stale_cfg = stale;
        @(negedge clk);
        subtract = s; in_a = a; in_b = b; in_m = m; start = 1'b1;
        t0 = cyc;
        exp_cyc = (passes == 1) ? t0 + la + 2 : t0 + 2 * la + 4;
        @(negedge clk);
        // scramble inputs to show operands were latched at accept
        start = 1'b0; subtract = ~s;
        in_a = rnd_bits(W); in_b = rnd_bits(W); in_m = rnd_bits(W);
        n_starts = 0; got = 0; busy_ok = 1; first_ok = 1; k = 0; dcyc = 0; got_r = '0;
        while (!got && k < 200) begin
            if (adder_start) begin
                n_starts++;
                if (n_starts == 1 && (adder_a !== a || adder_b !== b || adder_subtract !== s))
                    first_ok = 0;
            end
            if (busy !== 1'b1) busy_ok = 0;
            if (done === 1'b1) begin
                got = 1; dcyc = cyc; got_r = result;
            end else begin
                start = (extra_start && cyc == t0 + 2) ? 1'b1 : 1'b0;
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s timeout: no done within 200 cycles (required a done pulse)", name);
        end else begin
            checks += 4;
            if (got_r !== exp_r) begin
                failures++;
                $display("FAIL %s result got=%0h required=%0h (low 128 bits)", name, got_r[127:0], exp_r[127:0]);
            end
            if (dcyc !== exp_cyc) begin
                failures++;
                $display("FAIL %s latency done_cycle=%0d required=%0d", name, dcyc - t0, exp_cyc - t0);
            end
            if (n_starts !== passes) begin
                failures++;
                $display("FAIL %s adder_start pulses=%0d required=%0d", name, n_starts, passes);
            end
            if (!busy_ok || !first_ok) begin
                failures++;
                $display("FAIL %s busy_held=%0d first_pass_operands_ok=%0d required 1/1", name, busy_ok, first_ok);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done done=%0b busy=%0b required 0/0", name, done, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || adder_start !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_after busy=%0b adder_start=%0b required 0/0", name, busy, adder_start);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if (result !== '0 || done !== 1'b0 || busy !== 1'b0 || adder_start !== 1'b0 ||
            adder_subtract !== 1'b0 || adder_a !== '0 || adder_b !== '0) begin
            failures++;
            $display("FAIL %s outputs result=%0h done=%0b busy=%0b ast=%0b asub=%0b a=%0h b=%0h required all 0",
                     name, result[63:0], done, busy, adder_start, adder_subtract, adder_a[63:0], adder_b[63:0]);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        resetn = 1'b1;
        @(negedge clk);
        check_zero_outputs("reset_idle");
    endtask

    task automatic test_add();
        run_op(1'b0, W'(7), W'(9), W'(13), 2, 0, 0, "add_7_9");
        run_op(1'b0, W'(5), W'(8), W'(13), 1, 0, 0, "add_eq_m");
        run_op(1'b0, W'(2), W'(3), W'(13), 3, 0, 0, "add_borrow");
        run_op(1'b0, W'(0), W'(0), W'(1), 1, 0, 0, "add_m1");
    endtask

    task automatic test_sub();
        run_op(1'b1, W'(9), W'(3), W'(13), 3, 0, 0, "sub_pos");
        run_op(1'b1, W'(3), W'(9), W'(13), 2, 0, 0, "sub_neg");
        run_op(1'b1, W'(4), W'(4), W'(13), 1, 0, 0, "sub_zero");
    endtask

    task automatic test_wide();
        logic [W-1:0] m;
        m = {W{1'b1}} >> 2;
        run_op(1'b0, m - W'(1), m - W'(1), m, 2, 0, 0, "wide_add");
        run_op(1'b1, W'(0), m - W'(1), m, 3, 0, 0, "wide_sub");
    endtask

    task automatic test_stale_extra_start();
        run_op(1'b0, W'(7), W'(9), W'(13), 4, 1, 1, "stale_done_extra_start");
        run_op(1'b1, W'(3), W'(9), W'(13), 4, 1, 1, "stale_done_sub");
    endtask

    task automatic test_reset_mid_op();
        int n, k;
        bit saw_done;
        lat_cfg = 3; stale_cfg = 0;
        @(negedge clk);
        subtract = 1'b0; in_a = W'(7); in_b = W'(9); in_m = W'(13); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; k = 0;
        while (n < 2 && k < 50) begin
            if (adder_start) n++;
            if (n < 2) begin @(negedge clk); k++; end
        end
        checks++;
        if (n != 2) begin
            failures++;
            $display("FAIL midreset reach_p2 starts=%0d required=2", n);
        end
        resetn = 1'b0;
        @(negedge clk);
        check_zero_outputs("midreset");
        resetn = 1'b1;
        saw_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL midreset spurious_done got=1 required=0");
        end
        run_op(1'b0, W'(11), W'(12), W'(13), 2, 0, 0, "after_midreset");
    endtask

    task automatic test_random();
        int widths[3] = '{8, 64, W - 1};
        logic [W-1:0] m, a, b;
        int nb;
        for (int i = 0; i < 24; i++) begin
            nb = widths[$urandom_range(0, 2)];
            m = rnd_bits(nb);
            if (m == '0) m = W'(1);
            a = rnd_bits(W - 1) % m;
            b = rnd_bits(W - 1) % m;
            run_op(1'(($urandom & 1)), a, b, m, int'($urandom_range(1, 6)), 0, 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_wide();
        test_stale_extra_start();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached required finish before limit");
        $fatal(1, "timeout");
    end
endmodule
